// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// It holds the program counter, a word-addressed instruction memory with a
// debug load port, and the IF/ID pipeline register that feeds id_stage.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   i_enable         global run enable (0 behaves as a stall)
//   i_stall          hold PC and IF/ID (load-use hazard from ID)
//   i_flush          replace IF/ID contents with a bubble
//   i_branch_taken   redirect fetch to i_branch_target
//   i_branch_target  byte address of the redirect
//   i_imem_we        debug write strobe
//   i_imem_addr      debug byte address (bits [1:0] ignored)
//   i_imem_wdata     debug write data
//   o_instruction    IF/ID instruction
//   o_next_pc        IF/ID PC+4
//   o_pc             IF/ID PC of the instruction
//   o_valid          IF/ID holds a real instruction
//   o_halted         fetch is in the HALTED state
// ---------------------------------------------------------------------------
module if_stage #(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_imem_we,
   input  logic [31:0] i_imem_addr,
   input  logic [31:0] i_imem_wdata,
   output logic [31:0] o_instruction,
   output logic [31:0] o_next_pc,
   output logic [31:0] o_pc,
   output logic        o_valid,
   output logic        o_halted
);

   localparam int AW = $clog2(IMEM_DEPTH);

   typedef enum logic {RUN, HALTED} state_t;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] next_pc;
      logic [31:0] pc;
      logic        valid;
   } ifid_t;

   // A bubble decodes as an R-type writing $0, so it is architecturally inert.
   localparam ifid_t BUBBLE = '0;

   state_t      state;
   ifid_t       ifid;
   logic [31:0] pc;
   logic [31:0] mem [IMEM_DEPTH];

   logic        fetch_in_range;
   logic        wr_in_range;
   logic [31:0] fetch_word;
   logic [31:0] pc_plus4;
   logic        fetch_is_halt;
   logic [31:0] pc_advance;
   logic        unused_bits;

   // Alignment bits are ignored on both byte-address inputs.
   assign unused_bits = ^{i_branch_target[1:0], i_imem_addr[1:0]};

   // Anything at or above 4*IMEM_DEPTH reads as a NOP; debug writes there are dropped.
   assign fetch_in_range = (pc[31:AW+2] == '0);
   assign wr_in_range    = (i_imem_addr[31:AW+2] == '0);
   assign fetch_word     = fetch_in_range ? mem[pc[AW+1:2]] : 32'h0;
   assign pc_plus4       = pc + 32'd4;
   assign fetch_is_halt  = (fetch_word == HALT_WORD);
   // On a HALT word the PC parks on it instead of advancing.
   assign pc_advance     = fetch_is_halt ? pc : pc_plus4;

   // NOTE: the instruction array has no reset so it maps onto RAM; program
   // contents survive a reset and are loaded through the debug port.
   always_ff @(posedge clk) begin
      if (i_imem_we && wr_in_range) begin
         mem[i_imem_addr[AW+1:2]] <= i_imem_wdata;
      end
   end

   // Branch > flush > stall/!enable > halted > normal fetch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc    <= RESET_PC;
         state <= RUN;
         ifid  <= BUBBLE;
      end else if (i_branch_taken) begin
         pc    <= {i_branch_target[31:2], 2'b00};
         state <= RUN;
         ifid  <= BUBBLE;
      end else if (i_flush) begin
         ifid <= BUBBLE;
         // A flushed HALT word is not acted on; it is simply refetched.
         if (i_enable && !i_stall && state == RUN) begin
            pc <= pc_advance;
         end
      end else if (!i_enable || i_stall) begin
         // PC, IF/ID and state all hold.
      end else if (state == HALTED) begin
         ifid <= BUBBLE;
      end else begin
         ifid.instruction <= fetch_word;
         ifid.next_pc     <= pc_plus4;
         ifid.pc          <= pc;
         ifid.valid       <= 1'b1;
         pc               <= pc_advance;
         if (fetch_is_halt) begin
            state <= HALTED;
         end
      end
   end

   assign o_instruction = ifid.instruction;
   assign o_next_pc     = ifid.next_pc;
   assign o_pc          = ifid.pc;
   assign o_valid       = ifid.valid;
   assign o_halted      = (state == HALTED);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   localparam int          DEPTH = 256;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        clk;
   logic        reset;
   logic        i_enable, i_stall, i_flush, i_branch_taken, i_imem_we;
   logic [31:0] i_branch_target, i_imem_addr, i_imem_wdata;
   logic [31:0] o_instruction, o_next_pc, o_pc;
   logic        o_valid, o_halted;

   int checks   = 0;
   int failures = 0;

   if_stage #(
      .IMEM_DEPTH (DEPTH),
      .RESET_PC   (32'h0000_0000),
      .HALT_WORD  (HALT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .i_enable        (i_enable),
      .i_stall         (i_stall),
      .i_flush         (i_flush),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .i_imem_we       (i_imem_we),
      .i_imem_addr     (i_imem_addr),
      .i_imem_wdata    (i_imem_wdata),
      .o_instruction   (o_instruction),
      .o_next_pc       (o_next_pc),
      .o_pc            (o_pc),
      .o_valid         (o_valid),
      .o_halted        (o_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model (architectural view) ----------------
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_pc, m_instr, m_npc, m_opc;
   logic        m_valid, m_halted;

   function automatic logic [31:0] m_fetch(input logic [31:0] a);
      if (a < 32'(DEPTH * 4)) return m_mem[a[9:2]];
      return 32'h0;
   endfunction

   task automatic m_bubble();
      m_instr = 32'h0; m_npc = 32'h0; m_opc = 32'h0; m_valid = 1'b0;
   endtask

   task automatic m_reset();
      m_pc = 32'h0; m_halted = 1'b0;
      m_bubble();
   endtask

   // One clock edge of the specified behaviour, using the inputs now applied.
   task automatic model_edge();
      logic [31:0] w;
      w = m_fetch(m_pc);
      if (reset) begin
         if (i_branch_taken) begin
            m_pc = {i_branch_target[31:2], 2'b00};
            m_halted = 1'b0;
            m_bubble();
         end else if (i_flush) begin
            m_bubble();
            if (i_enable && !i_stall && !m_halted && w != HALT) m_pc = m_pc + 4;
         end else if (!i_enable || i_stall) begin
            // everything holds
         end else if (m_halted) begin
            m_bubble();
         end else begin
            m_instr = w; m_npc = m_pc + 4; m_opc = m_pc; m_valid = 1'b1;
            if (w == HALT) m_halted = 1'b1;
            else m_pc = m_pc + 4;
         end
      end
      if (i_imem_we && i_imem_addr < 32'(DEPTH * 4))
         m_mem[i_imem_addr[9:2]] = i_imem_wdata;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] e_instr,
                             input logic [31:0] e_npc, input logic [31:0] e_pc,
                             input logic e_valid, input logic e_halted);
      check({tag, "_instr"},  o_instruction, e_instr);
      check({tag, "_npc"},    o_next_pc,     e_npc);
      check({tag, "_pc"},     o_pc,          e_pc);
      check({tag, "_valid"},  {31'h0, o_valid},  {31'h0, e_valid});
      check({tag, "_halted"}, {31'h0, o_halted}, {31'h0, e_halted});
   endtask

   task automatic idle_inputs();
      i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_branch_taken = 1'b0;
      i_branch_target = 32'h0; i_imem_we = 1'b0; i_imem_addr = 32'h0; i_imem_wdata = 32'h0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        en, stall, flush, br;
      logic [31:0] tgt;
      logic [31:0] e_instr, e_npc, e_pc;
      logic        e_valid, e_halted;
   } vec_t;

   vec_t vecs [18];

   initial begin
      logic [31:0] w;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h20010005, 32'h4,   32'h0,  1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h20020007, 32'h8,   32'h4,  1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h20020007, 32'h8,   32'h4,  1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h20020007, 32'h8,   32'h4,  1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00221820, 32'hC,   32'h8,  1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h42, 32'h0,        32'h0,   32'h0,  1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h8C040000, 32'h44,  32'h40, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hC,  32'h0,        32'h0,   32'h0,  1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00000020, 32'h10,  32'hC,  1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'hFFFFFFFF, 32'h14,  32'h10, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,   32'h0,  1'b0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,   32'h0,  1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,        32'h0,   32'h0,  1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h20010005, 32'h4,   32'h0,  1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0,        32'h0,   32'h0,  1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00221820, 32'hC,   32'h8,  1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00221820, 32'hC,   32'h8,  1'b1, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h00000020, 32'h10,  32'hC,  1'b1, 1'b0};

      // Reset asserted asynchronously: outputs must clear without a clock edge.
      idle_inputs();
      reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      m_reset();
      check_outs("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Program load through the debug port while reset is held.
      for (int i = 0; i < DEPTH; i++) begin
         case (i)
            0:  w = 32'h20010005;
            1:  w = 32'h20020007;
            2:  w = 32'h00221820;
            3:  w = 32'h00000020;
            4:  w = HALT;
            16: w = 32'h8C040000;
            default: begin
               w = $urandom;
               if (w == HALT) w = 32'h1234_5678;
            end
         endcase
         i_imem_we = 1'b1; i_imem_addr = 32'(i * 4); i_imem_wdata = w;
         step();
      end
      idle_inputs();
      check_outs("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Release reset between edges.
      reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         i_enable = vecs[i].en; i_stall = vecs[i].stall; i_flush = vecs[i].flush;
         i_branch_taken = vecs[i].br; i_branch_target = vecs[i].tgt;
         step();
         check_outs($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_npc,
                    vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_halted);
      end
      idle_inputs();

      // Asynchronous reset mid-run, between edges, with a valid instruction held.
      @(negedge clk);
      reset = 1'b0;
      #1;
      m_reset();
      check_outs("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      check_outs("restart", 32'h20010005, 32'h4, 32'h0, 1'b1, 1'b0);

      // Out-of-range fetch returns a NOP; out-of-range debug write is dropped.
      i_branch_taken = 1'b1; i_branch_target = 32'h400;
      step();
      check_outs("oor_redirect", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      idle_inputs();
      step();
      check_outs("oor_fetch", 32'h0, 32'h404, 32'h400, 1'b1, 1'b0);
      i_enable = 1'b0; i_imem_we = 1'b1; i_imem_addr = 32'h400; i_imem_wdata = 32'hDEADBEEF;
      step();
      idle_inputs();
      i_branch_taken = 1'b1; i_branch_target = 32'h0;
      step();
      idle_inputs();
      step();
      check_outs("oor_wr_dropped", 32'h20010005, 32'h4, 32'h0, 1'b1, 1'b0);

      // Debug write to the word being fetched: same cycle sees old data, later sees new.
      i_imem_we = 1'b1; i_imem_addr = 32'h4; i_imem_wdata = 32'h11112222;
      step();
      check_outs("wr_same_cycle", 32'h20020007, 32'h8, 32'h4, 1'b1, 1'b0);
      idle_inputs();
      i_branch_taken = 1'b1; i_branch_target = 32'h4;
      step();
      idle_inputs();
      step();
      check_outs("wr_next_fetch", 32'h11112222, 32'h8, 32'h4, 1'b1, 1'b0);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         i_enable        = ($urandom % 10) != 0;
         i_stall         = ($urandom % 7) == 0;
         i_flush         = ($urandom % 10) == 0;
         i_branch_taken  = ($urandom % 7) == 0;
         i_branch_target = $urandom_range(0, 32'h47F);
         i_imem_we       = ($urandom % 3) == 0;
         i_imem_addr     = $urandom_range(0, 32'h47F);
         i_imem_wdata    = (($urandom % 8) == 0) ? HALT : $urandom;
         step();
         check_outs($sformatf("rand%0d", n), m_instr, m_npc, m_opc, m_valid, m_halted);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `id_stage`. It holds the program counter and a word-addressed instruction memory with a debug load port, and registers the IF/ID pipeline register that supplies `id_stage` with the instruction and PC+4. It also handles stall, flush, branch redirect and a sticky HALT state.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words (power of two, ≥ 4).
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset (word aligned).
- `HALT_WORD`, 32'hFFFF_FFFF: encoding that stops fetch.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `i_enable`  in  1  global run enable; 0 behaves as stall.
- `i_stall`  in  1  hold the PC and the IF/ID register (load-use hazard from ID).
- `i_flush`  in  1  replace the IF/ID contents with a bubble.
- `i_branch_taken`  in  1  redirect fetch to `i_branch_target`.
- `i_branch_target`  in  32  byte address of the redirect.
- `i_imem_we`  in  1  debug write strobe.
- `i_imem_addr`  in  32  debug byte address; bits [1:0] ignored.
- `i_imem_wdata`  in  32  debug write data.
- `o_instruction`  out  32  IF/ID instruction, to `id_stage` `i_instruction`.
- `o_next_pc`  out  32  IF/ID PC+4, to `id_stage` `i_next_pc`.
- `o_pc`  out  32  IF/ID PC of the instruction.
- `o_valid`  out  1  IF/ID holds a real instruction.
- `o_halted`  out  1  fetch is in the HALTED state.

## Operation
- Fetch word index = `pc[log2(IMEM_DEPTH)+1:2]`. The read is combinational from the array. A PC whose byte address is ≥ 4*IMEM_DEPTH reads 32'h0 (NOP).
- The memory is not cleared by reset. A debug write commits to word `i_imem_addr[log2(IMEM_DEPTH)+1:2]` at the clock edge. A write whose word address is out of range is dropped. Writes are accepted in every state, including reset-deasserted halt.
- The state machine has two states, RUN and HALTED. Reset enters RUN.
- Per-edge priority, highest first:
  1. `i_branch_taken`:
     - pc ← `{i_branch_target[31:2],2'b00}`.
     - IF/ID ← bubble.
     - state ← RUN. This overrides stall, enable, flush and HALTED.
  2. `i_flush`: IF/ID ← bubble. PC advances as it does in the normal case when not stalled or halted.
  3. `!i_enable` or `i_stall`: PC, IF/ID and state hold.
  4. HALTED: PC holds and IF/ID ← bubble.
  5. Normal operation:
     - IF/ID ← {fetched word, pc+4, pc}, with valid=1.
     - pc ← pc+4, wrapping modulo 2^32.
     - If the fetched word equals `HALT_WORD`, pc holds instead, state ← HALTED, and the HALT word is still passed down with valid=1.
- A bubble is instruction 32'h0, next_pc 0, pc 0, valid 0. The control unit decodes opcode 0 as an R-type that writes $0, which is harmless.
- Flush and stall asserted together: the flush wins for IF/ID and the PC holds.

## Timing
- Reset values: pc=`RESET_PC`, state=RUN, `o_instruction`=0, `o_next_pc`=0, `o_pc`=0, `o_valid`=0, `o_halted`=0. Outputs take these values immediately on `reset` falling, independent of `clk`.
- Reset is released synchronously by the integrator. The first fetch from `RESET_PC` appears on the outputs after the first rising edge following deassertion.
- Fetch latency is 1 cycle. An instruction at PC p appears on `o_instruction` the edge after pc=p.
- Branch penalty as seen by this block: the redirect edge produces one bubble, and the target instruction appears on the next edge.
- `o_halted` rises on the same edge that registers the HALT word.
- Debug write followed by a fetch of the same word: a fetch in the same cycle returns the old data; a fetch in the following cycle returns the new data.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset then sequential fetch: load words 0x20010005, 0x20020007, 0x00221820 at addresses 0, 4, 8, then deassert reset. Over three edges the outputs are (instr, next_pc, pc) = (0x20010005, 4, 0), (0x20020007, 8, 4), (0x00221820, 12, 8), each with valid=1.
- Stall: assert `i_stall` for 2 cycles while IF/ID holds pc=4. The outputs stay at (0x20020007, 8, 4) and pc=8 holds. After release the next output is pc=8.
- Branch plus stall collision: assert `i_branch_taken` with target 0x0000_0042 and `i_stall` in the same cycle. The next edge gives a bubble (valid=0, instr 0). The following edge gives pc=0x40 with the word at index 16.
- Halt: place 0xFFFFFFFF at 0x10. The edge that fetches it gives o_instruction=0xFFFFFFFF, valid=1, o_halted=1. Every later edge gives bubbles and pc stays at 0x10. A branch to 0 clears `o_halted` and fetch resumes at 0.
- Asynchronous reset mid-run: pull `reset` low between edges while valid=1. All outputs go to 0 before the next edge. After release, fetch restarts at `RESET_PC` and the memory contents are unchanged.
- Out of range and wrap: with IMEM_DEPTH=256, branch to 0x400. The fetched instruction is 0 with valid=1. A debug write to 0x400 is dropped, and reading 0x000 shows its original data.
